// File: rtl/pipelined_alu.sv
// Registered ALU with valid/ready handshake, tag passthrough and illegal-opcode flag.
// Define PIPELINED_ALU_MUL_EN to build the iterative shift-add MUL (opcode 17).
module pipelined_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             compare,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00, OP_SUB   = 5'h01, OP_AND   = 5'h02, OP_OR    = 5'h03,
    OP_XOR   = 5'h04, OP_NAND  = 5'h05, OP_NOR   = 5'h06, OP_XNOR  = 5'h07,
    OP_MVHI  = 5'h08, OP_F     = 5'h09, OP_EQ    = 5'h0A, OP_LT    = 5'h0B,
    OP_LTE   = 5'h0C, OP_T     = 5'h0D, OP_NE    = 5'h0E, OP_GTE   = 5'h0F,
    OP_GT    = 5'h10, OP_BEQZ  = 5'h11, OP_BLTZ  = 5'h12, OP_BLTEZ = 5'h13,
    OP_BNEZ  = 5'h14, OP_BGTEZ = 5'h15, OP_BGTZ  = 5'h16, OP_MUL   = 5'h17
  } op_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               compare_q, compare_d;
  logic               illegal_q, illegal_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic signed [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ill, is_cmp, cond, a_neg, a_zero;
  logic               accept, load_sc;

  assign sa     = $signed(a);
  assign sb     = $signed(b);
  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    is_cmp = 1'b0;
    cond   = 1'b0;
    case (op)
      OP_ADD:   sc_res = a + b;
      OP_SUB:   sc_res = a - b;
      OP_AND:   sc_res = a & b;
      OP_OR:    sc_res = a | b;
      OP_XOR:   sc_res = a ^ b;
      OP_NAND:  sc_res = ~(a & b);
      OP_NOR:   sc_res = ~(a | b);
      OP_XNOR:  sc_res = ~(a ^ b);
      OP_MVHI:  sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_F:     is_cmp = 1'b1;
      OP_EQ:    begin is_cmp = 1'b1; cond = (sa == sb); end
      OP_LT:    begin is_cmp = 1'b1; cond = (sa <  sb); end
      OP_LTE:   begin is_cmp = 1'b1; cond = (sa <= sb); end
      OP_T:     begin is_cmp = 1'b1; cond = 1'b1;       end
      OP_NE:    begin is_cmp = 1'b1; cond = (sa != sb); end
      OP_GTE:   begin is_cmp = 1'b1; cond = (sa >= sb); end
      OP_GT:    begin is_cmp = 1'b1; cond = (sa >  sb); end
      OP_BEQZ:  begin is_cmp = 1'b1; cond = a_zero;             end
      OP_BLTZ:  begin is_cmp = 1'b1; cond = a_neg;              end
      OP_BLTEZ: begin is_cmp = 1'b1; cond = a_neg | a_zero;     end
      OP_BNEZ:  begin is_cmp = 1'b1; cond = !a_zero;            end
      OP_BGTEZ: begin is_cmp = 1'b1; cond = !a_neg;             end
      OP_BGTZ:  begin is_cmp = 1'b1; cond = !a_neg && !a_zero;  end
`ifdef PIPELINED_ALU_MUL_EN
      OP_MUL:   sc_res = '0;
`endif
      default:  sc_ill = 1'b1;
    endcase
    if (is_cmp) sc_res = {{(WIDTH-1){1'b0}}, cond};
  end

`ifdef PIPELINED_ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH+1);

  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] mul_tag_q, mul_tag_d;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    compare_d   = compare_q;
    illegal_d   = illegal_q;
    out_tag_d   = out_tag_q;
    in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
`ifdef PIPELINED_ALU_MUL_EN
    load_sc     = accept && (op != OP_MUL);
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_tag_d   = mul_tag_q;
`else
    load_sc     = accept;
`endif

    // A consume and a fresh load on the same edge leave out_valid set.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (load_sc) begin
      out_valid_d = 1'b1;
      result_d    = sc_res;
      compare_d   = is_cmp & cond;
      illegal_d   = sc_ill;
      out_tag_d   = in_tag;
    end

`ifdef PIPELINED_ALU_MUL_EN
    case (state_q)
      IDLE: begin
        if (accept && (op == OP_MUL)) begin
          state_d   = MUL_RUN;
          mcand_d   = a;
          mplier_d  = b;
          acc_d     = '0;
          cnt_d     = '0;
          mul_tag_d = in_tag;
        end
      end
      MUL_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          result_d    = acc_q;
          compare_d   = 1'b0;
          illegal_d   = 1'b0;
          out_tag_d   = mul_tag_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      compare_q   <= 1'b0;
      illegal_q   <= 1'b0;
      out_tag_q   <= '0;
`ifdef PIPELINED_ALU_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_tag_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      compare_q   <= compare_d;
      illegal_q   <= illegal_d;
      out_tag_q   <= out_tag_d;
`ifdef PIPELINED_ALU_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_tag_q   <= mul_tag_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign compare   = compare_q;
  assign illegal   = illegal_q;
  assign out_tag   = out_tag_q;

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, registered successor of the single-cycle 32-bit ALU. Same 5-bit opcode map, adds valid/ready handshaking on both sides, a tag passthrough, illegal-opcode flagging and an iterative multi-cycle MUL.
- Sits between operand fetch/decode and writeback in the processor datapath.
- Single-cycle ops sustain one result per clock.

Parameters:
- WIDTH, 32: operand/result width; even, >= 8.
- TAG_W, 4: width of the caller tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A (signed for compare/branch ops).
- b  in  WIDTH  operand B.
- op  in  5  opcode.
- in_tag  in  TAG_W  caller tag.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- compare  out  1  condition bit for compare/branch ops; 0 otherwise.
- illegal  out  1  opcode unsupported.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Opcodes:
  - ADD 00, SUB 01, AND 02, OR 03, XOR 04, NAND 05, NOR 06, XNOR 07.
  - MVHI 08: result = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - Compares, signed a vs b: F 09, EQ 0A, LT 0B, LTE 0C, T 0D, NE 0E, GTE 0F, GT 10.
  - Branch compares, signed a vs 0: BEQZ 11, BLTZ 12, BLTEZ 13, BNEZ 14, BGTEZ 15, BGTZ 16.
  - MUL 17.
- Compare and branch ops: compare = condition, result = zero-extended condition. All other ops: compare = 0.
- ADD/SUB wrap modulo 2^WIDTH. No overflow output.
- Opcodes 18-1F: result = 0, compare = 0, illegal = 1. Latency is single-cycle.
- Accept: when in_valid && in_ready at a rising edge, operands, op and tag are captured.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Single-cycle ops: the output register loads at the accept edge, so out_valid is 1 the following cycle. Back-to-back accepts give one result per cycle while out_ready = 1.
- Output hold: while out_valid && !out_ready, result, compare, illegal and out_tag are held stable. out_valid clears on the handshake edge unless a new result loads at the same edge.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
  - IDLE -> MUL_RUN: on accepting MUL. Latch a and b, clear the accumulator, counter = 0.
  - MUL_RUN: each cycle, if multiplier bit0 = 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; increment the counter. After WIDTH cycles, go to MUL_DONE.
  - MUL_DONE: load the output register with the low WIDTH bits of the product (signed and unsigned agree) when !out_valid || out_ready, then go to IDLE. Otherwise wait in MUL_DONE.
- MUL latency with out_ready = 1: out_valid asserts WIDTH+1 cycles after the accept edge.
- in_ready = 0 throughout MUL_RUN and MUL_DONE.
- Counter width is $clog2(WIDTH+1).
- Reset: asynchronous, at any time including mid-MUL. Effects: state = IDLE; out_valid = 0; result = 0, compare = 0, illegal = 0, out_tag = 0; accumulator and counter = 0; in_ready = 1 once reset_n deasserts. An in-flight operation is discarded.
- Simultaneous consume and accept in the same cycle: the new result replaces the old one and out_valid stays 1.

Optional Feature:
- Macro: PIPELINED_ALU_MUL_EN.
- Defined: MUL and its FSM are implemented as described above.
- Undefined: no multiplier logic is synthesised and the FSM stays in IDLE. Opcode 17 is treated as illegal: single-cycle, result = 0, illegal = 1.

Test Plan:
- WIDTH=32, a=55, b=109, ops ADD, SUB, AND, OR, XOR issued back-to-back with out_ready=1 -> results 164, 0xFFFFFFCA, 37, 127, 90 on consecutive cycles; tags preserved in order.
- a=55, b=109: LT, GTE, MVHI -> compare/result 1/1, 0/0, 0/0x006D0000.
- a=-13: BEQZ, BLTZ, BLTEZ, BNEZ, BGTEZ, BGTZ -> compare 0, 1, 1, 1, 0, 0.
- MUL a=55, b=109 with the macro defined -> in_ready low 33 cycles; out_valid 33 cycles after accept; result 5995. Repeat with out_ready=0 for 5 cycles after completion -> block waits in MUL_DONE and result appears unchanged once drained. Same stimulus with the macro undefined -> illegal=1, result 0, 1-cycle latency.
- Backpressure: out_ready=0 while issuing ADD then SUB -> ADD result held and in_ready=0; raise out_ready -> ADD consumed, SUB accepted the same edge, SUB result next cycle.
- Assert reset_n=0 for 1 cycle mid-MUL (cycle 10) -> out_valid=0 and in_ready=1 immediately after release; no stale MUL result ever appears. Opcode 0x1F -> illegal=1, result=0.
